// File: rtl/counter_6bit_pkg.sv
// Shared constants for the 6-bit up/down pointer counter.
package counter_6bit_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  // Direction encoding carried on the D input.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage : counter_6bit_pkg

// File: rtl/updown_next.sv
// Combinational next-count logic: hold, increment or decrement modulo 2^W.
module updown_next
  import counter_6bit_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic [W-1:0] cnt_i,
  input  logic         en_i,
  input  logic         dir_i,
  output logic [W-1:0] cnt_next_o
);

  // Direction is examined only when enabled, so an unknown D while idle
  // cannot disturb the held value.
  always_comb begin
    cnt_next_o = cnt_i;
    if (en_i) begin
      if (dir_i == DIR_DOWN) begin
        cnt_next_o = cnt_i - 1'b1;
      end else begin
        cnt_next_o = cnt_i + 1'b1;
      end
    end
  end

endmodule : updown_next

// File: rtl/counter_6bit.sv
// 6-bit up/down counter: Q is the low ADDR_W bits, dau the wrap/phase MSB.
module counter_6bit
  import counter_6bit_pkg::*;
#(
  parameter int unsigned ADDR_W = counter_6bit_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              E,
  input  logic              D,
  output logic [ADDR_W-1:0] Q,
  output logic              dau
);

  localparam int unsigned W = ADDR_W + 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  updown_next #(
    .W (W)
  ) u_next (
    .cnt_i      (cnt_q),
    .en_i       (E),
    .dir_i      (D),
    .cnt_next_o (cnt_d)
  );

  // Count register with synchronous reset taking priority over counting.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Q   = cnt_q[ADDR_W-1:0];
  assign dau = cnt_q[ADDR_W];

endmodule : counter_6bit

// File: tb/tb_counter_6bit.sv
// Self-checking bench for counter_6bit: behavioural model plus directed literals.
module tb_counter_6bit;

  logic       CLK;
  logic       reset;
  logic       E;
  logic       D;
  logic [4:0] Q;
  logic       dau;

  int unsigned checks;
  int unsigned fails;
  int unsigned m;        // model count, 0..63
  bit          m_valid;

  counter_6bit #(
    .ADDR_W (5)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .E     (E),
    .D     (D),
    .Q     (Q),
    .dau   (dau)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: update from the sampled inputs at each edge, then compare 1 time unit later.
  initial begin
    m       = 0;
    m_valid = 1'b0;
    forever begin
      @(posedge CLK);
      if (reset === 1'b1) begin
        m       = 0;
        m_valid = 1'b1;
      end else if (E === 1'b1) begin
        if (D === 1'b1) m = (m + 63) % 64;
        else            m = (m + 1) % 64;
      end
      #1;
      if (m_valid) begin
        checks++;
        if (Q !== 5'(m % 32) || dau !== 1'(m / 32)) begin
          fails++;
          $display("FAIL model_cmp t=%0t: got dau=%0b Q=%0d, expected dau=%0d Q=%0d",
                   $time, dau, Q, m / 32, m % 32);
        end
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic d);
    @(negedge CLK);
    reset = r;
    E     = e;
    D     = d;
    @(posedge CLK);
    #2;
  endtask

  // Literal check of both the DUT and the model against a hand-computed value.
  task automatic chk(input string name, input logic [5:0] exp);
    logic [5:0] mv;
    mv = 6'(m);
    checks++;
    if ({dau, Q} !== exp) begin
      fails++;
      $display("FAIL %s: got dau=%0b Q=%0d, expected dau=%0b Q=%0d",
               name, dau, Q, exp[5], exp[4:0]);
    end
    checks++;
    if (mv !== exp) begin
      fails++;
      $display("FAIL %s_model: model=%0d, expected %0d", name, mv, exp);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b0;
    E      = 1'b0;
    D      = 1'b0;

    // Reset, then idle
    step(1'b1, 1'b0, 1'b0);
    chk("reset", 6'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("idle_after_reset", 6'd0);
    end

    // Count up 1..5
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("count_up", 6'(i));
    end

    // Up wrap: 32 edges -> dau=1 Q=0, 64 edges -> 0
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 31; i++) step(1'b0, 1'b1, 1'b0);
    chk("up_31", 6'd31);
    step(1'b0, 1'b1, 1'b0);
    chk("up_wrap_32", 6'd32);
    for (int i = 0; i < 31; i++) step(1'b0, 1'b1, 1'b0);
    chk("up_63", 6'd63);
    step(1'b0, 1'b1, 1'b0);
    chk("up_wrap_64", 6'd0);

    // Down wrap from 0
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("down_wrap", 6'd63);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("down_61", 6'd61);
    // 32 -> 31 crosses the dau boundary downward
    for (int i = 0; i < 29; i++) step(1'b0, 1'b1, 1'b1);
    chk("down_32", 6'd32);
    step(1'b0, 1'b1, 1'b1);
    chk("down_31", 6'd31);

    // Hold with unknown D, then direction switch
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
    chk("to_7", 6'd7);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'bx);
      chk("hold_7", 6'd7);
    end
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("down_to_5", 6'd5);
    step(1'b0, 1'b1, 1'b0);
    chk("switch_up_6", 6'd6);

    // Reset priority over enable
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
    chk("to_12", 6'd12);
    step(1'b1, 1'b1, 1'b0);
    chk("reset_priority", 6'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("resume_1", 6'd1);

    // Randomised traffic checked by the model process
    for (int i = 0; i < 3000; i++) begin
      logic r, e, d;
      r = ($urandom_range(99) < 2);
      e = ($urandom_range(99) < 70);
      d = 1'($urandom);
      if (!e && $urandom_range(3) == 0) d = 1'bx;
      step(r, e, d);
    end

    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_counter_6bit

// File: doc/counter_6bit.md
COUNTER_6BIT -- requirements
Module: counter_6bit

Interface
REQ-001 Parameter: ADDR_W, default 5, width of Q; the internal count is ADDR_W+1 = 6 bits.
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: E  input  1  count enable; 1 = count this cycle, 0 = hold.
REQ-005 Port: D  input  1  direction; 0 = count up, 1 = count down; sampled only when E=1.
REQ-006 Port: Q  output  ADDR_W (5)  lower bits of the 6-bit count (pointer/address field).
REQ-007 Port: dau  output  1  MSB (bit 5) of the 6-bit count; wrap/phase flag.
REQ-008 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-009 The block SHALL hold a 6-bit register cnt; Q = cnt[4:0], dau = cnt[5], both driven directly from flops (no combinational path from inputs).
REQ-010 Priority at each rising CLK edge SHALL be: reset, then E, then hold.
REQ-011 reset=1: cnt SHALL become 0 at that edge, regardless of E and D.
REQ-012 reset=0, E=0: cnt SHALL hold its value; D ignored, including X/Z on D.
REQ-013 reset=0, E=1, D=0: cnt SHALL become (cnt+1) mod 64.
REQ-014 reset=0, E=1, D=1: cnt SHALL become (cnt-1) mod 64.
REQ-015 Latency: an enabled count SHALL be visible on Q/dau immediately after the edge at which E=1 was sampled; one step per enabled edge.
REQ-016 Up wrap-around: {dau,Q}=1,31 SHALL go to 0,0; {dau,Q}=0,31 SHALL go to 1,0 (dau toggles each time Q wraps).
REQ-017 Down wrap-around: {dau,Q}=0,0 SHALL go to 1,31; {dau,Q}=1,0 SHALL go to 0,31.
REQ-018 A change of D between consecutive enabled cycles SHALL take effect at the next edge with no dead cycle.
REQ-019 Arithmetic SHALL be unsigned modulo 2^(ADDR_W+1); no saturation, no overflow output.

Reset
REQ-020 Reset values: Q=0, dau=0.
REQ-021 Reset asserted mid-count SHALL clear cnt at the next rising edge; counting resumes from 0 at the first enabled edge after deassertion.
REQ-022 Before the first reset edge, outputs are undefined; no initial-value assignments SHALL be relied upon.

Structure
REQ-023 A shared package counter_6bit_pkg SHALL hold ADDR_W default (5), CNT_W = ADDR_W+1, and direction constants DIR_UP=0, DIR_DOWN=1.
REQ-024 One combinational sub-module, updown_next, SHALL compute the next count from (cnt, E, D); counter_6bit SHALL contain the register and reset logic.
REQ-025 No latches, no asynchronous logic, no gated clocks.

Verification
REQ-026 Reset: reset=1 for one edge with E=0, D=0 -> Q=0, dau=0; after reset=0 with E=0 for 3 edges -> Q stays 0.
REQ-027 Count up: reset released, then E=1, D=0 for 5 edges -> Q=1,2,3,4,5, dau=0.
REQ-028 Up wrap: E=1, D=0 for 32 edges from 0 -> Q=0, dau=1; 64 edges -> Q=0, dau=0.
REQ-029 Down wrap: from 0, E=1, D=1 for 1 edge -> Q=31, dau=1; 2 more edges -> Q=29, dau=1.
REQ-030 Hold/direction switch: count to 7, E=0 for 4 edges -> Q=7; E=1, D=1 for 2 edges -> Q=5.
REQ-031 Reset priority: at Q=12, assert reset with E=1, D=0 for one edge -> Q=0, dau=0; release -> next enabled edge gives Q=1.
